// File: rtl/l1_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_prefetch_pkg
// Purpose  : Shared constants and types for the L1 prefetch responder.
//            Holds the prefetch cache commands, the line-address type and
//            the s1/s2 verdict-tracking record.
// Revision : 1.0 - initial release
// ============================================================================
package l1_prefetch_pkg;

  // Line-address width for the standard configuration (40-bit PA, 64 B
  // lines). The responder's ADDR_BITS - LINE_SHIFT must equal LINE_BITS.
  localparam int PKG_ADDR_BITS  = 40;
  localparam int PKG_LINE_SHIFT = 6;
  localparam int LINE_BITS      = PKG_ADDR_BITS - PKG_LINE_SHIFT;

  localparam logic [4:0] M_PFR = 5'b00010;  // prefetch for read
  localparam logic [4:0] M_PFW = 5'b00011;  // prefetch for write

  typedef logic [LINE_BITS-1:0] line_t;

  // One stage of the verdict pipeline.
  typedef struct packed {
    logic  valid;     // an accept occupies this stage
    logic  filtered;  // it was suppressed by the filter (never issued)
    line_t line;      // its line address
  } track_t;

endpackage : l1_prefetch_pkg
`default_nettype wire

// File: rtl/prefetch_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_line_filter
// Purpose  : Small fully-associative recent-line filter with round-robin
//            replacement.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_lookup_line     - line to look up; o_hit is combinational
//                                from register state
//            i_insert          - write i_insert_line at the RR pointer and
//            i_insert_line       advance the pointer
//            i_inval           - invalidate every valid entry whose line
//            i_inval_line        equals i_inval_line
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_line_filter #(
  parameter int ENTRIES = 8,   // power of two, >= 2
  parameter int LINE_W  = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] i_lookup_line,
  output logic              o_hit,
  input  logic              i_insert,
  input  logic [LINE_W-1:0] i_insert_line,
  input  logic              i_inval,
  input  logic [LINE_W-1:0] i_inval_line
);

  localparam int PTR_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [LINE_W-1:0]  r_line [ENTRIES];
  logic [PTR_W-1:0]   r_ptr;

  logic [ENTRIES-1:0] w_match;
  logic [ENTRIES-1:0] w_ins;
  logic [ENTRIES-1:0] w_kill;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    assign w_match[gi] = r_valid[gi] && (r_line[gi] == i_lookup_line);
    assign w_ins[gi]   = i_insert && (r_ptr == PTR_W'(gi));
    assign w_kill[gi]  = i_inval && r_valid[gi] && (r_line[gi] == i_inval_line);
  end

  assign o_hit = |w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        // Insert takes precedence over an invalidate hitting the same slot.
        if (w_ins[i]) begin
          r_valid[i] <= 1'b1;
        end else if (w_kill[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      // ENTRIES is a power of two, so the natural wrap is the modulo.
      if (i_insert) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  // Line tags need no reset: they are qualified by r_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_ins[i]) begin
        r_line[i] <= i_insert_line;
      end
    end
  end

endmodule : prefetch_line_filter
`default_nettype wire

// File: rtl/l1_prefetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : l1_prefetch_responder
// Purpose  : Accepts prefetcher requests, drops recently seen lines and
//            issues the rest to the L1 D-cache port when the core is idle.
//            Each accept yields a pf_nack verdict exactly two cycles later.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            pf_req_*                - prefetcher request (ready/valid)
//            pf_nack                 - verdict for the accept of cycle t-2
//            cpu_req_valid           - core owns the cache port this cycle
//            cache_req_*             - prefetch issue to the cache
//            cache_s2_nack           - cache rejects the request of t-2
//            issued_count            - prefetches issued (wrapping)
//            filtered_count          - accepts suppressed by the filter
// Revision : 1.0 - initial release
// ============================================================================
module l1_prefetch_responder
  import l1_prefetch_pkg::*;
#(
  parameter int ADDR_BITS      = 40,
  parameter int CMD_BITS       = 5,
  parameter int LINE_SHIFT     = 6,  // ADDR_BITS - LINE_SHIFT must be LINE_BITS
  parameter int FILTER_ENTRIES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pf_req_valid,
  output logic                 pf_req_ready,
  input  logic [ADDR_BITS-1:0] pf_req_bits_addr,
  input  logic                 pf_req_bits_write,
  output logic                 pf_nack,
  input  logic                 cpu_req_valid,
  input  logic                 cache_req_ready,
  output logic                 cache_req_valid,
  output logic [ADDR_BITS-1:0] cache_req_bits_addr,
  output logic [CMD_BITS-1:0]  cache_req_bits_cmd,
  input  logic                 cache_s2_nack,
  output logic [31:0]          issued_count,
  output logic [31:0]          filtered_count
);

  line_t       w_line;
  logic        w_accept;
  logic        w_hit;
  logic        w_issue;
  logic        w_inval;

  track_t      r_s1;
  track_t      r_s2;
  logic [31:0] r_issued;
  logic [31:0] r_filtered;

  assign w_line = line_t'(pf_req_bits_addr[ADDR_BITS-1:LINE_SHIFT]);

  // No buffering: a request is only taken when it can go straight out.
  assign pf_req_ready = !reset && cache_req_ready && !cpu_req_valid;
  assign w_accept     = pf_req_valid && pf_req_ready;
  assign w_issue      = w_accept && !w_hit;

  assign cache_req_valid     = w_issue;
  assign cache_req_bits_addr = {w_line, {LINE_SHIFT{1'b0}}};
  assign cache_req_bits_cmd  = pf_req_bits_write ? CMD_BITS'(M_PFW)
                                                 : CMD_BITS'(M_PFR);

  // A cache nack only means something when s2 holds an issued request;
  // dropping its line from the filter lets an immediate retry go out.
  assign w_inval = r_s2.valid && !r_s2.filtered && cache_s2_nack;

  assign pf_nack = !reset && r_s2.valid && (r_s2.filtered || cache_s2_nack);

  prefetch_line_filter #(
    .ENTRIES (FILTER_ENTRIES),
    .LINE_W  (LINE_BITS)
  ) u_filter (
    .clk           (clock),
    .rst           (reset),
    .i_lookup_line (w_line),
    .o_hit         (w_hit),
    .i_insert      (w_issue),
    .i_insert_line (w_line),
    .i_inval       (w_inval),
    .i_inval_line  (r_s2.line)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_issued   <= '0;
      r_filtered <= '0;
    end else begin
      r_s1.valid    <= w_accept;
      r_s1.filtered <= w_accept && w_hit;
      r_s1.line     <= w_line;
      r_s2          <= r_s1;
      if (w_issue) begin
        r_issued <= r_issued + 32'd1;
      end
      if (w_accept && w_hit) begin
        r_filtered <= r_filtered + 32'd1;
      end
    end
  end

  assign issued_count   = r_issued;
  assign filtered_count = r_filtered;

endmodule : l1_prefetch_responder
`default_nettype wire
